// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the FSM state encoding and the byte/word widths used by the
// loader top level, its byte packer and its bus interface.
package imem_loader_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the loader and its controller, the byte source and the
// instruction ROM write port.
//   start/len              : load request (len sampled on start)
//   byte_in/valid/ready    : byte stream handshake
//   we/waddr/wdata         : ROM write port (registered)
//   cpu_hold/busy/done     : status towards the CPU and controller
// master: stream source / controller side.  slave: the loader.
interface imem_loader_if #(parameter int width = 5);
    import imem_loader_pkg::*;

    logic               start;
    logic [width:0]     len;
    logic [BYTE_W-1:0]  byte_in;
    logic               byte_valid;
    logic               byte_ready;
    logic               we;
    logic [width-1:0]   waddr;
    logic [WORD_W-1:0]  wdata;
    logic               cpu_hold;
    logic               busy;
    logic               done;

    modport master (
        output start, len, byte_in, byte_valid,
        input  byte_ready, we, waddr, wdata, cpu_hold, busy, done
    );

    modport slave (
        input  start, len, byte_in, byte_valid,
        output byte_ready, we, waddr, wdata, cpu_hold, busy, done
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words.
//   clk, CLR   : clock, asynchronous active-high reset
//   byte_in    : incoming byte
//   take       : byte_in is consumed this cycle
//   clear      : drop any partial word and restart at lane 0
//   word       : assembled word including the byte being taken this cycle
//   word_full  : this take fills lane 3, so word is complete now
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              CLR,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              take,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);
    logic [1:0]        lane;
    logic [WORD_W-1:0] asm_q;

    // Merge the byte being taken so the caller can register the complete
    // word on the same edge as the 4th handshake.
    always_comb begin
        word = asm_q;
        for (int k = 0; k < 4; k++) begin
            if (take && lane == 2'(k)) word[k*BYTE_W +: BYTE_W] = byte_in;
        end
        word_full = take && (lane == 2'd3);
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            lane  <= 2'd0;
            asm_q <= '0;
        end else if (clear) begin
            lane  <= 2'd0;
            asm_q <= '0;
        end else if (take) begin
            lane  <= lane + 2'd1;   // wraps to lane 0 after a full word
            asm_q <= word;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Write side of the instruction ROM. Takes a byte stream, packs it into
// little-endian words and writes them to word addresses 0..len-1, holding
// the CPU in reset (cpu_hold) for the duration of the load.
//   clk  : clock
//   CLR  : asynchronous active-high reset
//   bus  : imem_loader_if slave (request, byte stream, ROM write, status)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int width = 5
) (
    input  logic          clk,
    input  logic          CLR,
    imem_loader_if.slave  bus
);
    localparam logic [width:0] DEPTH = {1'b1, {width{1'b0}}};

    state_t            state_q, state_d;
    logic [width:0]    target_q, wcnt_q, wcnt_inc;
    logic [width-1:0]  waddr_q;
    logic [WORD_W-1:0] wdata_q, word;
    logic              we_q, take, full, idle_like, load_go;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign load_go   = idle_like && bus.start && (bus.len != '0);
    assign take      = (state_q == LOAD) && bus.byte_valid;
    assign wcnt_inc  = wcnt_q + 1'b1;

    imem_loader_byte_packer u_packer (
        .clk       (clk),
        .CLR       (CLR),
        .byte_in   (bus.byte_in),
        .take      (take),
        .clear     (load_go),
        .word      (word),
        .word_full (full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (bus.start) state_d = (bus.len == '0) ? DONE : LOAD;
            LOAD:       if (full) state_d = WRITE;
            WRITE:      state_d = (wcnt_inc == target_q) ? DONE : LOAD;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state_q  <= IDLE;
            target_q <= '0;
            wcnt_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // we is high exactly for the WRITE cycle that follows the 4th byte
            we_q    <= full;
            if (full) wdata_q <= word;
            if (load_go) begin
                // Clamp so waddr can never wrap past the end of the ROM
                target_q <= (bus.len > DEPTH) ? DEPTH : bus.len;
                wcnt_q   <= '0;
                waddr_q  <= '0;
            end else if (state_q == WRITE) begin
                wcnt_q <= wcnt_inc;
                if (wcnt_inc != target_q) waddr_q <= waddr_q + 1'b1;
            end
        end
    end

    assign bus.byte_ready = (state_q == LOAD);
    assign bus.busy       = (state_q == LOAD) || (state_q == WRITE);
    assign bus.cpu_hold   = bus.busy;
    assign bus.done       = (state_q == DONE);
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
endmodule
